// File: rtl/vga_monitor.sv
// Passive VGA sink: locks to hsync/vsync timing, recovers visible pixel coordinates,
// flags sync timing violations and produces a rolling 32-bit signature per frame.
module vga_monitor #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  input  logic        clr_err,
  output logic        locked,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] pixel_rgb,
  output logic        frame_done,
  output logic [31:0] checksum,
  output logic [15:0] frame_count,
  output logic [3:0]  err
);

  localparam logic [11:0] H_TOTAL = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [11:0] H_FIRST = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [11:0] HS_LAST = 12'(H_SYNC - 1);
  localparam logic [10:0] V_TOTAL = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [10:0] V_FIRST = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [10:0] VS_LINES = 11'(V_SYNC);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t state, state_next;

  logic        hs_s1, vs_s1, hs_prev, vs_prev;
  logic [11:0] rgb_s1;
  logic        hfall, hrise, vfall, vrise, is_locked;

  logic [11:0] hcnt, hcnt_next;
  logic [10:0] vcnt, vcnt_next;
  logic [10:0] vs_lines, vs_lines_next;
  logic        line_armed, line_armed_next;
  logic [31:0] acc, acc_step, acc_next;
  logic        h_vis, v_vis, valid_next;
  logic [9:0]  x_next, y_next;
  logic [11:0] rgb_next;
  logic        done_next;
  logic [31:0] checksum_next;
  logic [15:0] frame_count_next;
  logic [3:0]  viol, err_next;

  // Sync history resets high so a sync already low at reset release reads as a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_s1   <= 1'b1;
      vs_s1   <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      rgb_s1  <= '0;
    end else begin
      hs_s1   <= hsync;
      vs_s1   <= vsync;
      hs_prev <= hs_s1;
      vs_prev <= vs_s1;
      rgb_s1  <= {r, g, b};
    end
  end

  assign hfall     = ~hs_s1 & hs_prev;
  assign hrise     = hs_s1 & ~hs_prev;
  assign vfall     = ~vs_s1 & vs_prev;
  assign vrise     = vs_s1 & ~vs_prev;
  assign is_locked = (state == LOCKED);
  assign locked    = is_locked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SEARCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == SEARCH && vfall) state_next = LOCKED;
  end

  always_comb begin
    hcnt_next = hcnt;
    if (hfall)                hcnt_next = '0;
    else if (hcnt != 12'hFFF) hcnt_next = hcnt + 12'd1;

    // A vsync fall restarts the frame even when it lands on an hsync fall.
    vcnt_next = vcnt;
    if (vfall)                          vcnt_next = '0;
    else if (hfall && vcnt != 11'h7FF)  vcnt_next = vcnt + 11'd1;

    vs_lines_next = vs_lines;
    if (vfall)                                          vs_lines_next = 11'd1;
    else if (hfall && !vs_s1 && vs_lines != 11'h7FF)    vs_lines_next = vs_lines + 11'd1;

    line_armed_next = line_armed | (is_locked & hfall);

    h_vis      = (hcnt_next >= H_FIRST) && (hcnt_next <= H_LAST);
    v_vis      = (vcnt_next >= V_FIRST) && (vcnt_next <= V_LAST);
    valid_next = is_locked && h_vis && v_vis;
    x_next     = valid_next ? 10'(hcnt_next - H_FIRST) : '0;
    y_next     = valid_next ? 10'(vcnt_next - V_FIRST) : '0;
    rgb_next   = valid_next ? rgb_s1 : '0;

    acc_step = valid_next ? ({acc[30:0], acc[31]} ^ {20'b0, rgb_s1}) : acc;
    acc_next = vfall ? '0 : acc_step;

    done_next        = is_locked && vfall;
    checksum_next    = done_next ? acc_step : checksum;
    frame_count_next = done_next ? frame_count + 16'd1 : frame_count;
  end

  // Timing checks only mean something once the frame structure is known.
  always_comb begin
    viol    = '0;
    viol[0] = is_locked && ((hfall && line_armed && (hcnt + 12'd1) != H_TOTAL) ||
                            hcnt == 12'hFFF);
    viol[1] = is_locked && hrise && (hcnt != HS_LAST);
    viol[2] = is_locked && vfall && ((vcnt + 11'd1) != V_TOTAL);
    viol[3] = is_locked && vrise && (vs_lines != VS_LINES);
    err_next = (clr_err ? 4'b0000 : err) | viol;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      vs_lines    <= '0;
      line_armed  <= 1'b0;
      acc         <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_rgb   <= '0;
      frame_done  <= 1'b0;
      checksum    <= '0;
      frame_count <= '0;
      err         <= '0;
    end else begin
      hcnt        <= hcnt_next;
      vcnt        <= vcnt_next;
      vs_lines    <= vs_lines_next;
      line_armed  <= line_armed_next;
      acc         <= acc_next;
      pixel_valid <= valid_next;
      pixel_x     <= x_next;
      pixel_y     <= y_next;
      pixel_rgb   <= rgb_next;
      frame_done  <= done_next;
      checksum    <= checksum_next;
      frame_count <= frame_count_next;
      err         <= err_next;
    end
  end

endmodule

// File: tb/tb_vga_monitor.sv
// Bench for vga_monitor on a shrunken raster; a scoreboard checks pixels and frame results
// while directed frames inject sync timing faults and a mid-frame reset.
module tb_vga_monitor;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int X0 = HS + HB;
  localparam int Y0 = VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, clr_err;
  logic [3:0]  r, g, b;
  logic        locked, pixel_valid, frame_done;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] pixel_rgb;
  logic [31:0] checksum;
  logic [15:0] frame_count;
  logic [3:0]  err;

  always #5 clk = ~clk;

  vga_monitor #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .clr_err(clr_err),
    .locked(locked), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .frame_done(frame_done), .checksum(checksum),
    .frame_count(frame_count), .err(err)
  );

  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [11:0] rgb;} pix_t;
  typedef struct packed {logic [31:0] sum; logic [15:0] cnt;} frm_t;

  pix_t pix_q[$];
  frm_t frm_q[$];
  pix_t pe;
  frm_t fe;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        exp_locked = 1'b0;
  logic [31:0] exp_acc = '0;
  logic [15:0] exp_fcount = '0;
  logic        use_hand = 1'b0;
  logic [31:0] hand_sum = '0;
  int          rst_hold = 0;
  int          frame_idx = 0;

  int   cfg_mode, cfg_lines, cfg_vs, cfg_short_line, cfg_hs_line, cfg_rst_line, cfg_rst_col;
  logic cfg_clr;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [11:0] pattern(input int mode, input int px, input int py);
    case (mode)
      0:       return (((px >> 1) ^ (py >> 1)) & 1) != 0 ? 12'hF0F : 12'h0A0;
      1:       return (px == HV - 1 && py == VV - 1) ? 12'hFFF : 12'h000;
      2:       return (py == VV - 1 && px >= HV - 2) ? 12'h001 : 12'h000;
      default: return 12'(px * 299 + py * 97 + frame_idx * 13);
    endcase
  endfunction

  task automatic set_cfg(input int mode);
    cfg_mode = mode;
    cfg_lines = VT;
    cfg_vs = VS;
    cfg_short_line = -1;
    cfg_hs_line = -1;
    cfg_rst_line = -1;
    cfg_rst_col = -1;
    cfg_clr = 1'b0;
  endtask

  task automatic drive_cycle(input logic h, input logic v, input logic [11:0] rgb,
                             input logic clr);
    hsync = h;
    vsync = v;
    {r, g, b} = rgb;
    clr_err = clr;
    @(posedge clk);
    #1;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst = 1'b1;
    end
  endtask

  task automatic do_reset_mid_frame();
    rst = 1'b0;
    #1;
    check_output("reset locked",      32'(locked),      32'd0);
    check_output("reset pixel_valid", 32'(pixel_valid), 32'd0);
    check_output("reset pixel_x",     32'(pixel_x),     32'd0);
    check_output("reset pixel_y",     32'(pixel_y),     32'd0);
    check_output("reset pixel_rgb",   32'(pixel_rgb),   32'd0);
    check_output("reset frame_done",  32'(frame_done),  32'd0);
    check_output("reset checksum",    checksum,         32'd0);
    check_output("reset frame_count", 32'(frame_count), 32'd0);
    check_output("reset err",         32'(err),         32'd0);
    pix_q.delete();
    frm_q.delete();
    exp_locked = 1'b0;
    exp_acc = '0;
    exp_fcount = '0;
    rst_hold = 3;
  endtask

  // Drives one frame per the cfg_* settings and queues the responses it should produce.
  task automatic apply_stimulus();
    for (int ln = 0; ln < cfg_lines; ln++) begin
      int llen, hsw;
      llen = (ln == cfg_short_line) ? HT - 1 : HT;
      hsw  = (ln == cfg_hs_line) ? HS - 1 : HS;
      for (int col = 0; col < llen; col++) begin
        logic h, v, vis;
        logic [11:0] rgb;
        int px, py;
        h = (col < hsw) ? 1'b0 : 1'b1;
        v = (ln < cfg_vs) ? 1'b0 : 1'b1;
        px = col - X0;
        py = ln - Y0;
        vis = (px >= 0 && px < HV && py >= 0 && py < VV);
        rgb = vis ? pattern(cfg_mode, px, py) : 12'h5A5;
        if (ln == 0 && col == 0) begin
          if (exp_locked) begin
            frm_q.push_back('{sum: (use_hand ? hand_sum : exp_acc), cnt: exp_fcount + 16'd1});
            exp_fcount = exp_fcount + 16'd1;
            use_hand = 1'b0;
          end
          exp_locked = 1'b1;
          exp_acc = '0;
        end
        if (vis && exp_locked) begin
          pix_q.push_back('{x: 10'(px), y: 10'(py), rgb: rgb});
          exp_acc = {exp_acc[30:0], exp_acc[31]} ^ {20'b0, rgb};
        end
        drive_cycle(h, v, rgb, cfg_clr && ln == 0 && col == 5);
        if (ln == cfg_rst_line && col == cfg_rst_col) do_reset_mid_frame();
      end
    end
    frame_idx++;
  endtask

  logic fd_prev = 1'b0;
  int   vis_count = 0;

  always @(negedge clk) begin
    if (!rst) begin
      vis_count = 0;
      fd_prev = 1'b0;
    end else begin
      if (fd_prev) check_output("frame_done pulse width", 32'(frame_done), 32'd0);
      if (pixel_valid) begin
        vis_count++;
        if (pix_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected pixel: got x=%0d y=%0d, required no pixel_valid",
                   pixel_x, pixel_y);
        end else begin
          pe = pix_q.pop_front();
          check_output("pixel_x",   32'(pixel_x),   32'(pe.x));
          check_output("pixel_y",   32'(pixel_y),   32'(pe.y));
          check_output("pixel_rgb", 32'(pixel_rgb), 32'(pe.rgb));
        end
      end
      if (frame_done) begin
        if (frm_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected frame_done: got frame_count=%0d, required no pulse",
                   frame_count);
        end else begin
          fe = frm_q.pop_front();
          check_output("checksum",        checksum,          fe.sum);
          check_output("frame_count",     32'(frame_count),  32'(fe.cnt));
          check_output("pixels per frame", 32'(vis_count),   32'(HV * VV));
        end
        vis_count = 0;
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    n_fail++;
    $display("[TB] FAIL watchdog: got no end of test within 20000 cycles, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    {r, g, b} = 12'h000;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("init locked",      32'(locked),      32'd0);
    check_output("init pixel_valid", 32'(pixel_valid), 32'd0);
    check_output("init frame_done",  32'(frame_done),  32'd0);
    check_output("init frame_count", 32'(frame_count), 32'd0);
    check_output("init checksum",    checksum,         32'd0);
    check_output("init err",         32'(err),         32'd0);
    rst = 1'b1;
    repeat (2) drive_cycle(1'b1, 1'b1, 12'h000, 1'b0);

    for (int f = 0; f < 3; f++) begin
      set_cfg(0);
      apply_stimulus();
    end
    check_output("locked after 3 falls",      32'(locked),      32'd1);
    check_output("frame_count after 3 falls", 32'(frame_count), 32'd2);
    check_output("err after 3 falls",         32'(err),         32'd0);

    set_cfg(1);
    apply_stimulus();
    hand_sum = 32'h00000FFF;
    use_hand = 1'b1;

    set_cfg(2);
    apply_stimulus();
    hand_sum = 32'h00000003;
    use_hand = 1'b1;

    set_cfg(3);
    cfg_short_line = Y0 + 1;
    apply_stimulus();
    check_output("err short line", 32'(err), 32'h1);

    set_cfg(3);
    cfg_clr = 1'b1;
    apply_stimulus();
    check_output("err after clr", 32'(err), 32'h0);

    set_cfg(0);
    cfg_hs_line = Y0 + 3;
    apply_stimulus();
    check_output("err narrow hsync", 32'(err), 32'h2);

    set_cfg(3);
    cfg_clr = 1'b1;
    cfg_lines = VT - 1;
    apply_stimulus();
    check_output("err before short frame ends", 32'(err), 32'h0);

    set_cfg(0);
    apply_stimulus();
    check_output("err short frame", 32'(err), 32'h4);

    set_cfg(0);
    cfg_clr = 1'b1;
    cfg_vs = VS + 1;
    apply_stimulus();
    check_output("err wide vsync", 32'(err), 32'h8);

    set_cfg(0);
    cfg_rst_line = Y0 + 2;
    cfg_rst_col = X0 + 3;
    apply_stimulus();
    check_output("locked before relock", 32'(locked), 32'd0);

    set_cfg(0);
    apply_stimulus();
    check_output("locked after relock",      32'(locked),      32'd1);
    check_output("frame_count after relock", 32'(frame_count), 32'd0);
    check_output("err after relock",         32'(err),         32'd0);

    set_cfg(3);
    apply_stimulus();

    set_cfg(0);
    cfg_lines = 2;
    apply_stimulus();
    repeat (6) drive_cycle(1'b1, 1'b1, 12'h000, 1'b0);

    check_output("final frame_count", 32'(frame_count), 32'd2);
    check_output("final err",         32'(err),         32'd0);
    check_output("pixel queue drained", 32'(pix_q.size()), 32'd0);
    check_output("frame queue drained", 32'(frm_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
